// File: rtl/seven_segment_scan_driver.sv
// seven_segment_scan_driver
// Time-multiplexed N-digit seven-segment driver. A pending frame is written by
// load; the active frame is swapped in only when the scan wraps to digit 0, so
// a digit never changes in the middle of a frame. Decodes hex 0-F with per-digit
// decimal point, forced blanking and optional leading-zero suppression.
module seven_segment_scan_driver #(
    parameter int NUM_DIGITS       = 4,
    parameter int SCAN_DIV         = 50000,
    parameter int SEG_ACTIVE_LOW   = 1,
    parameter int DIGIT_ACTIVE_LOW = 1,
    parameter int LZ_SUPPRESS      = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    output logic [6:0]                seg_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     digit_en,
    output logic                      frame_start
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(SCAN_DIV);

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    // Idle (unlit / deselected) pin levels, which depend on board polarity.
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF =
        (DIGIT_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    // Hex digit to active-high segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b0111111;
            4'h1:    s = 7'b0000110;
            4'h2:    s = 7'b1011011;
            4'h3:    s = 7'b1001111;
            4'h4:    s = 7'b1100110;
            4'h5:    s = 7'b1101101;
            4'h6:    s = 7'b1111101;
            4'h7:    s = 7'b0000111;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1100111;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b1111100;
            4'hC:    s = 7'b0111001;
            4'hD:    s = 7'b1011110;
            4'hE:    s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    // Input buses viewed as per-digit nibbles.
    logic [NUM_DIGITS-1:0][3:0] bcd_vec;
    assign bcd_vec = bcd_in;

    // Scan position.
    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic          slot_end;
    logic          frame_end;

    assign slot_end  = (presc == PRESC_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Double-buffered frame.
    logic [NUM_DIGITS-1:0][3:0] pend_bcd, act_bcd;
    logic [NUM_DIGITS-1:0]      pend_dp, act_dp;
    logic [NUM_DIGITS-1:0]      pend_blank, act_blank;

    // Delayed wrap marker so frame_start lines up with the registered outputs.
    logic wrap_q;

    // Prescaler and digit index: advance one digit every SCAN_DIV cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (slot_end) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Pending bank: last load before the frame boundary wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_bcd   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
        end else if (load) begin
            pend_bcd   <= bcd_vec;
            pend_dp    <= dp_in;
            pend_blank <= blank_in;
        end
    end

    // Active bank: swap at the wrap; a load on that same edge bypasses pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_bcd   <= '0;
            act_dp    <= '0;
            act_blank <= '0;
        end else if (frame_end) begin
            act_bcd   <= load ? bcd_vec  : pend_bcd;
            act_dp    <= load ? dp_in    : pend_dp;
            act_blank <= load ? blank_in : pend_blank;
        end
    end

    // Leading-zero chain: lead_zero[i] means digits i..top are all zero/blank.
    logic [NUM_DIGITS-1:0] digit_zero;
    logic [NUM_DIGITS-1:0] lead_zero;
    logic [NUM_DIGITS-1:0] dark;

    assign lead_zero[NUM_DIGITS-1] = digit_zero[NUM_DIGITS-1];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        assign digit_zero[g] = act_blank[g] || (act_bcd[g] == 4'h0);
        if (g < NUM_DIGITS - 1) begin : g_chain
            assign lead_zero[g] = digit_zero[g] && lead_zero[g+1];
        end
        // Digit 0 always shows something unless explicitly blanked.
        if (g == 0 || LZ_SUPPRESS == 0) begin : g_nolz
            assign dark[g] = act_blank[g];
        end else begin : g_lz
            assign dark[g] = act_blank[g] || lead_zero[g];
        end
    end

    // Current-digit decode, active-high before polarity.
    logic [6:0]            cur_seg;
    logic                  cur_dp;
    logic [NUM_DIGITS-1:0] cur_sel;

    assign cur_seg = dark[idx] ? 7'h00 : hex_to_seg(act_bcd[idx]);
    assign cur_dp  = !dark[idx] && act_dp[idx];
    assign cur_sel = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;

    // Output pins: registered, polarity applied last.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_out     <= SEG_OFF;
            dp_out      <= DP_OFF;
            digit_en    <= DIG_OFF;
            wrap_q      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            seg_out     <= (SEG_ACTIVE_LOW != 0)   ? ~cur_seg : cur_seg;
            dp_out      <= (SEG_ACTIVE_LOW != 0)   ? ~cur_dp  : cur_dp;
            digit_en    <= (DIGIT_ACTIVE_LOW != 0) ? ~cur_sel : cur_sel;
            wrap_q      <= frame_end;
            frame_start <= wrap_q;
        end
    end

endmodule
